dbg_clk_ctrl: RTL and testbench
===============================

DBG_CLK_CTRL -- requirements
Module: dbg_clk_ctrl

Interface
REQ-001 SHALL have parameter START_HALTED, default 0, meaning 1 = leave reset in HALT, 0 = leave reset in RUN.
REQ-002 SHALL have parameter RST_CYCLES, default 4, meaning dm_reset pulse length in sys_clk cycles (1..255).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: sys_clk input 1 (sole clock), then sys_reset_n input 1 (async assert, active low).
REQ-004 SHALL have port cmd_toggle input 1: TCK-domain command strobe; each level change = one new command.
REQ-005 SHALL have port cmd_code input 3: command, stable from the toggle change until the matching ack.
REQ-006 SHALL have port cmd_data input 32: command operand, stable under the same rule as cmd_code.
REQ-007 SHALL have port pc input 32: core fetch PC for breakpoint compare.
REQ-008 SHALL have port dbg_clk_en output 1: enable for the core clock gate.
REQ-009 SHALL have port dm_reset output 1: active-high core reset request.
REQ-010 SHALL have port halted output 1: high in HALT state.
REQ-011 SHALL have port halt_cause output 2: NONE / CMD / STEP / BP.
REQ-012 SHALL have port cmd_ack_toggle output 1: flips once per decoded command.
REQ-013 SHALL have port cmd_err output 1: sticky flag for an illegal cmd_code.

Function
REQ-014 SHALL synchronise cmd_toggle with 2 flops plus 1 history flop; an XOR edge yields a one-cycle cmd_valid.
REQ-015 SHALL decode on the cmd_valid cycle, with all outputs updated on the 3rd sys_clk edge after the toggle change is first sampled.
REQ-016 SHALL implement states RUN, HALT, STEP, RST.
REQ-017 SHALL drive dbg_clk_en = 1 in RUN and STEP, 0 in HALT, and hold the pre-RST value during RST.
REQ-018 SHALL handle command NOP (0) as ack only, with no state change.
REQ-019 SHALL handle command HALT (1) as a transition from any state except RST to HALT, with halt_cause = CMD.
REQ-020 SHALL handle command RUN (2) as a transition from HALT or STEP to RUN, with halt_cause = NONE.
REQ-021 SHALL handle command STEP (3) by loading a 16-bit counter with cmd_data[15:0] (0 treated as 1) and entering STEP.
REQ-022 SHALL keep dbg_clk_en high for exactly N cycles in STEP, then enter HALT with halt_cause = STEP.
REQ-023 SHALL restart the counter with the new N when STEP is received while in STEP.
REQ-024 SHALL handle command SET_BP (4) by registering bp_addr = cmd_data and bp_en = 1, with no state change.
REQ-025 SHALL handle command CLR_BP (5) by setting bp_en = 0.
REQ-026 SHALL handle command DMRST (6) by entering RST, asserting dm_reset for exactly RST_CYCLES cycles, then returning to the saved prior state, with the STEP remainder preserved.
REQ-027 SHALL, in RST, ack every command but ignore it (no queueing).
REQ-028 SHALL treat code 7 as illegal: ack it, set cmd_err, and make no state change.
REQ-029 SHALL clear cmd_err on the next legal command.
REQ-030 SHALL compare pc against bp_addr in RUN and STEP when bp_en = 1.
REQ-031 SHALL, on a breakpoint match, drive dbg_clk_en = 0 on the next edge, enter HALT and set halt_cause = BP.
REQ-032 SHALL not re-trigger the breakpoint while pc stays equal to bp_addr after RUN/STEP is issued from that address.
REQ-033 SHALL, when a breakpoint match and a cmd_valid fall in the same cycle, let the command win (a HALT still sets CMD).
REQ-034 SHALL, when the step count expires and a breakpoint matches in the same cycle, report halt_cause = BP.
REQ-035 SHALL hold the ack toggle and all state when cmd_toggle stops changing.

Reset
REQ-036 SHALL, on sys_reset_n low, immediately force: state = HALT if START_HALTED else RUN; dbg_clk_en = !START_HALTED; dm_reset = 0.
REQ-037 SHALL also, on sys_reset_n low, force: halted = START_HALTED; halt_cause = NONE; cmd_ack_toggle = 0; cmd_err = 0; bp_en = 0; counters = 0; all sync flops = 0.
REQ-038 SHALL, on reset mid-STEP or mid-RST, abandon the operation with no residual dm_reset.
REQ-039 SHALL leave the first command after deassertion detected only if cmd_toggle differs from 0.

Structure
REQ-040 SHALL place the cmd_e, state_e and halt_cause_e enums and the RST_CYCLES range limit in shared package dbg_pkg.
REQ-041 SHALL instantiate a single sub-module sync_2ff (1-bit, async active-low reset) for cmd_toggle.

Verification
REQ-042 SHALL cover: START_HALTED=1, reset released -> halted=1, dbg_clk_en=0, halt_cause=NONE.
REQ-043 SHALL cover: STEP with cmd_data=5 from HALT -> dbg_clk_en high exactly 5 cycles, then halt_cause=STEP, ack toggled once.
REQ-044 SHALL cover: SET_BP 0x0000_0010, RUN, pc reaches 0x10 -> dbg_clk_en=0 next edge, halt_cause=BP; RUN again -> no re-halt at 0x10.
REQ-045 SHALL cover: DMRST from RUN with RST_CYCLES=4 -> dm_reset high 4 cycles, RUN resumes; HALT sent during RST -> acked, ignored.
REQ-046 SHALL cover: cmd_code=7 -> cmd_err=1, state unchanged; then NOP -> cmd_err=0.
REQ-047 SHALL cover: sys_reset_n pulsed low mid-STEP (count 100) -> dm_reset=0 and the START_HALTED reset state immediately; after release no step continues.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and limits for the debug clock controller.
//   cmd_e        : command codes carried on cmd_code
//   state_e      : controller states
//   halt_cause_e : reason reported on halt_cause
//   rst_len()    : clamps the dm_reset pulse length into its legal range
package dbg_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_HALT    = 3'd1,
        CMD_RUN     = 3'd2,
        CMD_STEP    = 3'd3,
        CMD_SET_BP  = 3'd4,
        CMD_CLR_BP  = 3'd5,
        CMD_DMRST   = 3'd6,
        CMD_ILLEGAL = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2,
        ST_RST  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE = 2'd0,
        HC_CMD  = 2'd1,
        HC_STEP = 2'd2,
        HC_BP   = 2'd3
    } halt_cause_e;

    localparam int RST_CYCLES_MIN = 1;
    localparam int RST_CYCLES_MAX = 255;

    function automatic logic [7:0] rst_len(input int cycles);
        if (cycles < RST_CYCLES_MIN) begin
            return 8'(RST_CYCLES_MIN);
        end else if (cycles > RST_CYCLES_MAX) begin
            return 8'(RST_CYCLES_MAX);
        end else begin
            return cycles[7:0];
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronised output
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dbg_clk_ctrl.sv
// Debug clock controller: run/halt/single-step/reset control of a core clock
// gate, driven by toggle-handshake commands from the TCK domain.
//   sys_clk, sys_reset_n     : sole clock, async active-low reset
//   cmd_toggle               : each level change announces a new command
//   cmd_code, cmd_data       : command and operand, stable until acked
//   pc                       : core fetch PC for breakpoint compare
//   dbg_clk_en               : core clock gate enable
//   dm_reset                 : core reset request
//   halted, halt_cause       : HALT indication and reason
//   cmd_ack_toggle           : flips once per decoded command
//   cmd_err                  : sticky illegal-command flag
//
// state | meaning
// RUN   | core clock free running, breakpoint armed
// HALT  | core clock stopped
// STEP  | core clock running for a counted number of cycles
// RST   | dm_reset asserted, clock enable frozen, commands acked and dropped
module dbg_clk_ctrl
    import dbg_pkg::*;
#(
    parameter bit START_HALTED = 1'b0,
    parameter int RST_CYCLES   = 4
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic        cmd_toggle,
    input  logic [2:0]  cmd_code,
    input  logic [31:0] cmd_data,
    input  logic [31:0] pc,
    output logic        dbg_clk_en,
    output logic        dm_reset,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic        cmd_ack_toggle,
    output logic        cmd_err
);

    localparam logic [7:0] RST_LEN     = rst_len(RST_CYCLES);
    localparam state_e     RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;

    logic        tog_sync;
    logic        tog_hist_q;
    logic        cmd_valid;
    cmd_e        cmd;

    state_e      state_q, state_d;
    state_e      saved_q, saved_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [31:0] bp_addr_q, bp_addr_d;
    logic        bp_en_q, bp_en_d;
    logic        bp_skip_q, bp_skip_d;
    halt_cause_e cause_q, cause_d;
    logic        clk_en_q, clk_en_d;
    logic        dm_reset_q, dm_reset_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic        pc_at_bp;
    logic        bp_hit;
    logic        cmd_taken;

    sync_2ff u_tog_sync (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .d     (cmd_toggle),
        .q     (tog_sync)
    );

    assign cmd_valid = tog_sync ^ tog_hist_q;
    assign cmd       = cmd_e'(cmd_code);
    assign pc_at_bp  = (pc == bp_addr_q);
    // bp_skip lets the core leave the breakpoint address it was resumed from.
    assign bp_hit    = bp_en_q && pc_at_bp && !bp_skip_q;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            tog_hist_q <= 1'b0;
            state_q    <= RESET_STATE;
            saved_q    <= RESET_STATE;
            step_cnt_q <= 16'd0;
            rst_cnt_q  <= 8'd0;
            bp_addr_q  <= 32'd0;
            bp_en_q    <= 1'b0;
            bp_skip_q  <= 1'b0;
            cause_q    <= HC_NONE;
            clk_en_q   <= !START_HALTED;
            dm_reset_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tog_hist_q <= tog_sync;
            state_q    <= state_d;
            saved_q    <= saved_d;
            step_cnt_q <= step_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            bp_addr_q  <= bp_addr_d;
            bp_en_q    <= bp_en_d;
            bp_skip_q  <= bp_skip_d;
            cause_q    <= cause_d;
            clk_en_q   <= clk_en_d;
            dm_reset_q <= dm_reset_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        step_cnt_d = step_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        bp_addr_d  = bp_addr_q;
        bp_en_d    = bp_en_q;
        bp_skip_d  = bp_skip_q && pc_at_bp;
        cause_d    = cause_q;
        clk_en_d   = clk_en_q;
        dm_reset_d = dm_reset_q;
        ack_d      = ack_q ^ cmd_valid;
        err_d      = err_q;
        cmd_taken  = 1'b0;

        // Commands that change state pre-empt breakpoint and step expiry in
        // the same cycle; the others leave normal progress untouched.
        if (cmd_valid && (state_q != ST_RST)) begin
            err_d = (cmd == CMD_ILLEGAL);
            case (cmd)
                CMD_HALT: begin
                    state_d   = ST_HALT;
                    cause_d   = HC_CMD;
                    cmd_taken = 1'b1;
                end
                CMD_RUN: begin
                    if (state_q != ST_RUN) begin
                        state_d   = ST_RUN;
                        cause_d   = HC_NONE;
                        bp_skip_d = pc_at_bp;
                        cmd_taken = 1'b1;
                    end
                end
                CMD_STEP: begin
                    state_d    = ST_STEP;
                    step_cnt_d = (cmd_data[15:0] == 16'd0) ? 16'd1 : cmd_data[15:0];
                    cause_d    = HC_NONE;
                    bp_skip_d  = pc_at_bp;
                    cmd_taken  = 1'b1;
                end
                CMD_SET_BP: begin
                    bp_addr_d = cmd_data;
                    bp_en_d   = 1'b1;
                    bp_skip_d = 1'b0;
                end
                CMD_CLR_BP: begin
                    bp_en_d = 1'b0;
                end
                CMD_DMRST: begin
                    saved_d    = state_q;
                    state_d    = ST_RST;
                    rst_cnt_d  = RST_LEN;
                    dm_reset_d = 1'b1;
                    cmd_taken  = 1'b1;
                end
                default: ;
            endcase
        end

        if (!cmd_taken) begin
            case (state_q)
                ST_RUN: begin
                    if (bp_hit) begin
                        state_d = ST_HALT;
                        cause_d = HC_BP;
                    end
                end
                ST_STEP: begin
                    if (bp_hit) begin
                        state_d = ST_HALT;
                        cause_d = HC_BP;
                    end else if (step_cnt_q == 16'd1) begin
                        state_d    = ST_HALT;
                        cause_d    = HC_STEP;
                        step_cnt_d = 16'd0;
                    end else begin
                        step_cnt_d = step_cnt_q - 16'd1;
                    end
                end
                ST_RST: begin
                    if (rst_cnt_q == 8'd1) begin
                        state_d    = saved_q;
                        dm_reset_d = 1'b0;
                        rst_cnt_d  = 8'd0;
                    end else begin
                        rst_cnt_d = rst_cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end

        // The enable is registered from the next state so it changes on the
        // same edge as the state; RST keeps whatever the core had before.
        case (state_d)
            ST_RUN, ST_STEP: clk_en_d = 1'b1;
            ST_HALT:         clk_en_d = 1'b0;
            default:         clk_en_d = clk_en_q;
        endcase
    end

    assign dbg_clk_en     = clk_en_q;
    assign dm_reset       = dm_reset_q;
    assign halted         = (state_q == ST_HALT);
    assign halt_cause     = cause_q;
    assign cmd_ack_toggle = ack_q;
    assign cmd_err        = err_q;

endmodule

// File: tb/tb_dbg_clk_ctrl.sv
// Self-checking bench for dbg_clk_ctrl: directed scenarios plus a randomized
// command sequence checked against a command-level reference model.
module tb_dbg_clk_ctrl;

    localparam logic [2:0] C_NOP = 3'd0, C_HALT = 3'd1, C_RUN = 3'd2, C_STEP = 3'd3;
    localparam logic [2:0] C_SETBP = 3'd4, C_CLRBP = 3'd5, C_DMRST = 3'd6, C_BAD = 3'd7;
    localparam logic [1:0] H_NONE = 2'd0, H_CMD = 2'd1, H_STEP = 2'd2, H_BP = 2'd3;
    localparam int WIN = 30;

    logic        sys_clk = 1'b0;
    logic        sys_reset_n;
    logic        cmd_toggle;
    logic [2:0]  cmd_code;
    logic [31:0] cmd_data;
    logic [31:0] pc;

    logic        dbg_clk_en, dm_reset, halted, cmd_ack_toggle, cmd_err;
    logic [1:0]  halt_cause;
    logic        r_clk_en, r_dm_reset, r_halted, r_ack, r_err;
    logic [1:0]  r_cause;

    int   checks = 0;
    int   errors = 0;
    logic ack_exp = 1'b0;

    always #5 sys_clk = ~sys_clk;

    dbg_clk_ctrl #(.START_HALTED(1'b1), .RST_CYCLES(4)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .cmd_toggle(cmd_toggle),
        .cmd_code(cmd_code), .cmd_data(cmd_data), .pc(pc),
        .dbg_clk_en(dbg_clk_en), .dm_reset(dm_reset), .halted(halted),
        .halt_cause(halt_cause), .cmd_ack_toggle(cmd_ack_toggle), .cmd_err(cmd_err)
    );

    dbg_clk_ctrl #(.START_HALTED(1'b0), .RST_CYCLES(4)) dut_run (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .cmd_toggle(cmd_toggle),
        .cmd_code(cmd_code), .cmd_data(cmd_data), .pc(pc),
        .dbg_clk_en(r_clk_en), .dm_reset(r_dm_reset), .halted(r_halted),
        .halt_cause(r_cause), .cmd_ack_toggle(r_ack), .cmd_err(r_err)
    );

    // Returns #1 after the edge on which the command is decoded.
    task automatic send(input logic [2:0] code, input logic [31:0] data);
        @(negedge sys_clk);
        cmd_code   = code;
        cmd_data   = data;
        cmd_toggle = ~cmd_toggle;
        ack_exp    = ~ack_exp;
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted got %b want 1", halted); end
        checks++; if (dbg_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got %b want 0", dbg_clk_en); end
        checks++; if (halt_cause !== H_NONE) begin errors++; $display("FAIL reset_cause got %0d want 0", halt_cause); end
        checks++; if ({dm_reset, cmd_ack_toggle, cmd_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {dm_reset, cmd_ack_toggle, cmd_err}); end
        checks++; if ({r_halted, r_clk_en, r_cause} !== 4'b0100) begin errors++; $display("FAIL reset_run_inst got %b want 0100", {r_halted, r_clk_en, r_cause}); end
        checks++; if ({r_dm_reset, r_ack, r_err} !== 3'b000) begin errors++; $display("FAIL reset_run_flags got %b want 000", {r_dm_reset, r_ack, r_err}); end
    endtask

    task automatic test_step5();
        int cnt = 0;
        send(C_STEP, 32'hABCD_0005);
        for (int i = 0; i < 20; i++) begin
            if (dbg_clk_en) cnt++;
            @(posedge sys_clk); #1;
        end
        checks++; if (cnt != 5) begin errors++; $display("FAIL step5_cycles got %0d want 5", cnt); end
        checks++; if ({halted, halt_cause} !== {1'b1, H_STEP}) begin errors++; $display("FAIL step5_cause got %b/%0d want 1/2", halted, halt_cause); end
        checks++; if (cmd_ack_toggle !== ack_exp) begin errors++; $display("FAIL step5_ack got %b want %b", cmd_ack_toggle, ack_exp); end
    endtask

    task automatic test_breakpoint();
        int cnt = 0;
        send(C_SETBP, 32'h0000_0010);
        send(C_RUN, 32'd0);
        checks++; if ({dbg_clk_en, halted} !== 2'b10) begin errors++; $display("FAIL bp_run got %b want 10", {dbg_clk_en, halted}); end
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk); pc = 32'h10;
        @(posedge sys_clk); #1;
        checks++; if ({dbg_clk_en, halted, halt_cause} !== {2'b01, H_BP}) begin errors++; $display("FAIL bp_hit got %b want 0111", {dbg_clk_en, halted, halt_cause}); end
        send(C_RUN, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (dbg_clk_en) cnt++;
            @(posedge sys_clk); #1;
        end
        checks++; if (cnt != 10 || halted !== 1'b0) begin errors++; $display("FAIL bp_no_retrigger got %0d/%b want 10/0", cnt, halted); end
        @(negedge sys_clk); pc = 32'h14;
        @(negedge sys_clk); pc = 32'h10;
        @(posedge sys_clk); #1;
        checks++; if ({halted, halt_cause} !== {1'b1, H_BP}) begin errors++; $display("FAIL bp_rearm got %b/%0d want 1/3", halted, halt_cause); end
        // HALT decoded in the same cycle the breakpoint matches
        @(negedge sys_clk); pc = 32'h0;
        send(C_RUN, 32'd0);
        @(negedge sys_clk);
        cmd_code = C_HALT; cmd_toggle = ~cmd_toggle; ack_exp = ~ack_exp;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk); pc = 32'h10;
        @(posedge sys_clk); #1;
        checks++; if ({halted, halt_cause} !== {1'b1, H_CMD}) begin errors++; $display("FAIL bp_vs_cmd got %b/%0d want 1/1", halted, halt_cause); end
        // step expiry and breakpoint match in the same cycle
        @(negedge sys_clk); pc = 32'h0;
        send(C_STEP, 32'd3);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk); pc = 32'h10;
        @(posedge sys_clk); #1;
        checks++; if ({halted, halt_cause} !== {1'b1, H_BP}) begin errors++; $display("FAIL bp_vs_step got %b/%0d want 1/3", halted, halt_cause); end
        send(C_CLRBP, 32'd0);
        send(C_RUN, 32'd0);
        repeat (5) @(posedge sys_clk); #1;
        checks++; if ({dbg_clk_en, halted} !== 2'b10) begin errors++; $display("FAIL bp_cleared got %b want 10", {dbg_clk_en, halted}); end
        @(negedge sys_clk); pc = 32'h0;
    endtask

    task automatic test_dmrst();
        int cnt;
        send(C_DMRST, 32'd0);
        checks++; if ({dm_reset, dbg_clk_en, halted} !== 3'b110) begin errors++; $display("FAIL dmrst_enter got %b want 110", {dm_reset, dbg_clk_en, halted}); end
        cnt = 1;
        @(negedge sys_clk);
        cmd_code = C_HALT; cmd_toggle = ~cmd_toggle; ack_exp = ~ack_exp;
        for (int i = 0; i < 12; i++) begin
            @(posedge sys_clk); #1;
            if (dm_reset) cnt++;
        end
        checks++; if (cnt != 4) begin errors++; $display("FAIL dmrst_len got %0d want 4", cnt); end
        checks++; if ({halted, dbg_clk_en, halt_cause} !== {2'b01, H_NONE}) begin errors++; $display("FAIL dmrst_resume got %b want 0100", {halted, dbg_clk_en, halt_cause}); end
        checks++; if (cmd_ack_toggle !== ack_exp) begin errors++; $display("FAIL dmrst_ack got %b want %b", cmd_ack_toggle, ack_exp); end
    endtask

    task automatic test_illegal();
        send(C_BAD, 32'd0);
        checks++; if ({cmd_err, halted, dbg_clk_en} !== 3'b101) begin errors++; $display("FAIL illegal_set got %b want 101", {cmd_err, halted, dbg_clk_en}); end
        send(C_NOP, 32'd0);
        checks++; if ({cmd_err, halted, cmd_ack_toggle} !== {2'b00, ack_exp}) begin errors++; $display("FAIL illegal_clear got %b want 00%b", {cmd_err, halted, cmd_ack_toggle}, ack_exp); end
    endtask

    // Reference model tracks the settled controller state per command.
    task automatic test_random();
        logic       m_halted = 1'b0;
        logic [1:0] m_cause  = halt_cause;
        logic       m_err    = 1'b0;
        @(negedge sys_clk); pc = 32'hFFFF_FFF0;
        for (int it = 0; it < 25; it++) begin
            logic [2:0]  code = 3'($urandom_range(0, 7));
            logic [31:0] data = $urandom & 32'h7FFF_FFFF;
            int n = 0, en_exp, dm_exp = 0, en_cnt = 0, dm_cnt = 0;
            if (code == C_STEP) begin
                n = $urandom_range(0, 20);
                data = {data[31:16], 16'(n)};
            end
            m_err = (code == C_BAD);
            case (code)
                C_HALT:  begin m_halted = 1'b1; m_cause = H_CMD; end
                C_RUN:   if (m_halted) begin m_halted = 1'b0; m_cause = H_NONE; end
                C_STEP:  begin m_halted = 1'b1; m_cause = H_STEP; end
                C_DMRST: dm_exp = 4;
                default: ;
            endcase
            en_exp = (code == C_STEP) ? ((n == 0) ? 1 : n) : (m_halted ? 0 : WIN);
            send(code, data);
            for (int i = 0; i < WIN; i++) begin
                if (dbg_clk_en) en_cnt++;
                if (dm_reset) dm_cnt++;
                @(posedge sys_clk); #1;
            end
            checks++;
            if (en_cnt != en_exp || dm_cnt != dm_exp || halted !== m_halted || halt_cause !== m_cause
                || cmd_err !== m_err || cmd_ack_toggle !== ack_exp) begin
                errors++;
                $display("FAIL rand[%0d] code %0d: en %0d/%0d dm %0d/%0d halted %b/%b cause %0d/%0d err %b/%b ack %b/%b",
                         it, code, en_cnt, en_exp, dm_cnt, dm_exp, halted, m_halted,
                         halt_cause, m_cause, cmd_err, m_err, cmd_ack_toggle, ack_exp);
            end
        end
        @(negedge sys_clk); pc = 32'h0;
    endtask

    task automatic test_reset_mid_op();
        int cnt = 0;
        send(C_STEP, 32'd100);
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_reset_n = 1'b0; cmd_toggle = 1'b0; ack_exp = 1'b0;
        #1;
        checks++; if ({dm_reset, halted, dbg_clk_en, halt_cause} !== {3'b010, H_NONE}) begin errors++; $display("FAIL rst_mid_step got %b want 01000", {dm_reset, halted, dbg_clk_en, halt_cause}); end
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk); sys_reset_n = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge sys_clk); #1;
            if (dbg_clk_en) cnt++;
        end
        checks++; if (cnt != 0 || halted !== 1'b1) begin errors++; $display("FAIL rst_no_step got %0d/%b want 0/1", cnt, halted); end
        send(C_RUN, 32'd0);
        send(C_DMRST, 32'd0);
        checks++; if (dm_reset !== 1'b1) begin errors++; $display("FAIL rst_mid_rst_pre got %b want 1", dm_reset); end
        @(negedge sys_clk);
        sys_reset_n = 1'b0; cmd_code = C_NOP; cmd_toggle = 1'b1; ack_exp = 1'b0;
        #1;
        checks++; if ({dm_reset, halted, cmd_ack_toggle} !== 3'b010) begin errors++; $display("FAIL rst_mid_rst got %b want 010", {dm_reset, halted, cmd_ack_toggle}); end
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk); sys_reset_n = 1'b1;
        repeat (5) @(posedge sys_clk); #1;
        checks++; if ({cmd_ack_toggle, dm_reset, halted} !== 3'b101) begin errors++; $display("FAIL rst_first_cmd got %b want 101", {cmd_ack_toggle, dm_reset, halted}); end
    endtask

    initial begin
        sys_reset_n = 1'b0;
        cmd_toggle  = 1'b0;
        cmd_code    = 3'd0;
        cmd_data    = 32'd0;
        pc          = 32'd0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk); sys_reset_n = 1'b1;
        @(posedge sys_clk); #1;
        test_reset();
        test_step5();
        test_breakpoint();
        test_dmrst();
        test_illegal();
        test_random();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
